// File: rtl/axis_pipe_frame_fifo.sv
// Store-and-forward AXIS rx frame buffer feeding an AHIR read pipe.
// Optional `FRAME_STATS_EN adds saturating good/bad/overflow frame counters.
module axis_pipe_frame_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 10,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [DATA_W-1:0]   s_axis_tdata,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic                s_axis_tlast,
  input  logic                s_axis_tuser,
  input  logic                pipe_req,
  output logic                pipe_ack,
  output logic [DATA_W+1:0]   pipe_data,
  output logic [DEPTH_LOG2:0] frames_ready,
  output logic                overflow
`ifdef FRAME_STATS_EN
  ,
  input  logic                stats_clr,
  output logic [CNT_W-1:0]    good_frames,
  output logic [CNT_W-1:0]    bad_frames,
  output logic [CNT_W-1:0]    ovf_frames
`endif
);

  localparam int AW = DEPTH_LOG2;
  localparam int PW = DEPTH_LOG2 + 1;
  localparam int WW = DATA_W + 2;
  localparam logic [PW-1:0] DEPTH_P = {1'b1, {AW{1'b0}}};
  localparam logic [PW-1:0] ONE_P   = PW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_DROP
  } wr_st_e;

  logic [1:0]    rst_sync;
  logic          rst_n;

  wr_st_e        state, state_nxt;
  logic [PW-1:0] wr_ptr, wr_commit, rd_ptr;
  logic          accept, full;
  logic          we, commit, rewind, drop;

  logic [WW-1:0] mem [2**AW];
  logic [WW-1:0] a_q;
  logic          a_v;
  logic [WW-1:0] out_q;
  logic          out_v;
  logic          avail, xfer, move, issue, last_rd;

  // async assert, clock-aligned release
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign accept = s_axis_tvalid & s_axis_tready;
  assign full   = (wr_ptr - rd_ptr) == DEPTH_P;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_ACTIVE: begin
        if (accept) begin
          if (s_axis_tlast) state_nxt = S_IDLE;
          else if (full)    state_nxt = S_DROP;
          else              state_nxt = S_ACTIVE;
        end
      end
      S_DROP: begin
        if (accept && s_axis_tlast) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    we     = 1'b0;
    commit = 1'b0;
    rewind = 1'b0;
    drop   = 1'b0;
    unique case (state)
      S_IDLE, S_ACTIVE: begin
        if (accept) begin
          if (full) begin
            drop = 1'b1;
          end else begin
            we     = 1'b1;
            commit = s_axis_tlast & ~s_axis_tuser;
            rewind = s_axis_tlast & s_axis_tuser;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      wr_commit     <= '0;
      s_axis_tready <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      s_axis_tready <= 1'b1;
      overflow      <= drop;
      if (drop || rewind) wr_ptr <= wr_commit;
      else if (we)        wr_ptr <= wr_ptr + ONE_P;
      if (commit)         wr_commit <= wr_ptr + ONE_P;
    end
  end

  // storage and its registered read port carry no reset
  always_ff @(posedge clk) begin
    if (we)    mem[wr_ptr[AW-1:0]] <= {s_axis_tlast, s_axis_tdata, 1'b0};
    if (issue) a_q <= mem[rd_ptr[AW-1:0]];
  end

  // a_q is the prefetch slot behind the output word
  assign avail   = rd_ptr != wr_commit;
  assign xfer    = pipe_req & out_v;
  assign move    = a_v & (~out_v | xfer);
  assign issue   = avail & (~a_v | move);
  assign last_rd = xfer & out_q[WW-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      a_v    <= 1'b0;
      out_v  <= 1'b0;
      out_q  <= '0;
    end else begin
      if (issue) rd_ptr <= rd_ptr + ONE_P;
      a_v   <= issue | (a_v & ~move);
      out_v <= move | (out_v & ~xfer);
      if (move) out_q <= a_q;
    end
  end

  assign pipe_ack  = out_v;
  assign pipe_data = out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frames_ready <= '0;
    end else if (commit && !last_rd) begin
      frames_ready <= frames_ready + ONE_P;
    end else if (!commit && last_rd) begin
      frames_ready <= frames_ready - ONE_P;
    end
  end

`ifdef FRAME_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_frames <= '0;
      bad_frames  <= '0;
      ovf_frames  <= '0;
    end else if (stats_clr) begin
      good_frames <= '0;
      bad_frames  <= '0;
      ovf_frames  <= '0;
    end else begin
      if (commit && good_frames != '1) good_frames <= good_frames + CNT_W'(1);
      if (rewind && bad_frames != '1)  bad_frames  <= bad_frames + CNT_W'(1);
      if (drop && ovf_frames != '1)    ovf_frames  <= ovf_frames + CNT_W'(1);
    end
  end
`else
  logic [CNT_W-1:0] stats_unused;
  assign stats_unused = '0;
`endif

endmodule

// File: tb/tb_axis_pipe_frame_fifo.sv
// Randomised bench for axis_pipe_frame_fifo against a frame-level model.
// Build with +define+FRAME_STATS_EN to also check the frame counters.
module tb_axis_pipe_frame_fifo;

  localparam int DW = 8;
  localparam int DL = 4;
  localparam int CW = 16;
  localparam int DEPTH = 2**DL;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic          s_axis_tuser;
  logic          pipe_req;
  logic          pipe_ack;
  logic [DW+1:0] pipe_data;
  logic [DL:0]   frames_ready;
  logic          overflow;
`ifdef FRAME_STATS_EN
  logic          stats_clr;
  logic [CW-1:0] good_frames, bad_frames, ovf_frames;
`endif

  axis_pipe_frame_fifo #(
    .DATA_W(DW), .DEPTH_LOG2(DL), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast),
    .s_axis_tuser(s_axis_tuser),
    .pipe_req(pipe_req),
    .pipe_ack(pipe_ack),
    .pipe_data(pipe_data),
    .frames_ready(frames_ready),
    .overflow(overflow)
`ifdef FRAME_STATS_EN
    ,
    .stats_clr(stats_clr),
    .good_frames(good_frames),
    .bad_frames(bad_frames),
    .ovf_frames(ovf_frames)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [DW+1:0] exp_q[$];
  int committed_w = 0;
  int xfer_w = 0;
  int rd_mode = 0;
  int beats = 0;
  int ovf_seen = 0;
  int ovf_beat = -1;
  int fr_max = 0;
  int m_good = 0, m_bad = 0, m_ovf = 0;
  bit hold_v = 1'b0;
  logic [DW+1:0] hold_d;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // transfer monitor: each handshake pops the next expected word
  always @(negedge clk) begin
    if (reset_n) begin
      if (hold_v) begin
        chk("hold_ack", 32'(pipe_ack), 1);
        chk("hold_data", 32'(pipe_data), 32'(hold_d));
      end
      hold_v = pipe_ack && !pipe_req;
      hold_d = pipe_data;
      if (overflow) begin
        ovf_seen++;
        ovf_beat = beats;
      end
      if (int'(frames_ready) > fr_max) fr_max = int'(frames_ready);
      if (pipe_req && pipe_ack) begin
        logic [DW+1:0] e;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : (DW+2)'(1);
        chk("rd_word", 32'(pipe_data), 32'(e));
        xfer_w++;
      end
    end else begin
      hold_v = 1'b0;
    end
  end

  initial begin
    pipe_req = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rd_mode)
        0: pipe_req = 1'b0;
        1: pipe_req = 1'b1;
        2: pipe_req = 1'($urandom_range(0, 1));
        default: pipe_req = ~pipe_req;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int len, input logic [7:0] base,
                      input logic tu, input bit gaps, input bit rnd);
    logic [7:0] d[$];
    bit good;
    int w;
    w = 0;
    while (!s_axis_tready && w < 100) begin
      tick();
      w++;
    end
    if (w == 100) chk("tready_wait", 32'(s_axis_tready), 1);
    if (len <= DEPTH) begin
      w = 0;
      while ((committed_w - xfer_w + len) > DEPTH && w < 3000) begin
        tick();
        w++;
      end
      if (w == 3000) chk("space_wait", 32'(committed_w - xfer_w), 0);
    end
    good = !tu && len <= DEPTH;
    for (int i = 0; i < len; i++)
      d.push_back(rnd ? 8'($urandom) : 8'(base + 8'(i)));
    if (good) begin
      for (int i = 0; i < len; i++)
        exp_q.push_back({(i == len - 1), d[i], 1'b0});
      m_good++;
    end else if (len > DEPTH) begin
      m_ovf++;
    end else begin
      m_bad++;
    end
    for (int i = 0; i < len; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          s_axis_tvalid = 1'b0;
          tick();
        end
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d[i];
      s_axis_tlast  = (i == len - 1);
      s_axis_tuser  = (i == len - 1) ? tu : 1'($urandom);
      tick();
      beats++;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    if (good) committed_w += len;
  endtask

  task automatic drain(input string tag);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_left"}, 32'(exp_q.size()), 0);
    repeat (4) @(negedge clk);
    chk({tag, "_fr0"}, 32'(frames_ready), 0);
    chk({tag, "_ack0"}, 32'(pipe_ack), 0);
  endtask

  initial begin
    int n_big;
    reset_n = 1'b0;
    s_axis_tdata = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    s_axis_tuser = 1'b0;
`ifdef FRAME_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tready", 32'(s_axis_tready), 0);
    chk("rst_ack", 32'(pipe_ack), 0);
    chk("rst_data", 32'(pipe_data), 0);
    chk("rst_fr", 32'(frames_ready), 0);
    chk("rst_ovf", 32'(overflow), 0);
    tick();
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("tready_up", 32'(s_axis_tready), 1);

    // commit-to-ack latency with reader always requesting
    rd_mode = 1;
    tick();
    send(DEPTH, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("lat_n0_ack", 32'(pipe_ack), 0);
    chk("lat_fr1", 32'(frames_ready), 1);
    @(negedge clk);
    chk("lat_n1_ack", 32'(pipe_ack), 0);
    @(negedge clk);
    chk("lat_n2_ack", 32'(pipe_ack), 1);
    drain("lat");

    // errored frame rewound, good frame follows
    rd_mode = 0;
    tick();
    send(12, 8'h40, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("bad_fr0", 32'(frames_ready), 0);
    chk("bad_ack0", 32'(pipe_ack), 0);
    send(10, 8'h80, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("good_fr1", 32'(frames_ready), 1);
    chk("good_ack1", 32'(pipe_ack), 1);
    chk("good_first", 32'(pipe_data), 32'({1'b0, 8'h80, 1'b0}));
    rd_mode = 1;
    drain("bad");

    // oversize frame on an empty buffer
    rd_mode = 0;
    tick();
    beats = 0;
    ovf_seen = 0;
    send(20, 8'hA0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("big_ovf_n", 32'(ovf_seen), 1);
    chk("big_ovf_beat", 32'(ovf_beat), 17);
    chk("big_fr0", 32'(frames_ready), 0);
    chk("big_ack0", 32'(pipe_ack), 0);
    send(4, 8'hC0, 1'b0, 1'b0, 1'b0);
    rd_mode = 1;
    drain("big");

    // stalled consumer, then toggled requests
    rd_mode = 0;
    tick();
    send(3, 8'h10, 1'b0, 1'b0, 1'b0);
    send(4, 8'h20, 1'b0, 1'b0, 1'b0);
    send(5, 8'h30, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("hold_fr3", 32'(frames_ready), 3);
    chk("hold_ack1", 32'(pipe_ack), 1);
    chk("hold_first", 32'(pipe_data), 32'({1'b0, 8'h10, 1'b0}));
    repeat (6) @(negedge clk);
    rd_mode = 3;
    drain("tog");

    // streaming across pointer wrap
    rd_mode = 1;
    fr_max = 0;
    tick();
    for (int i = 0; i < 50; i++)
      send(5, 8'(i * 5), 1'b0, 1'b0, 1'b0);
    drain("wrap");
    chk("wrap_frmax_le3", 32'(fr_max <= 3), 1);

    // random frames, gaps and requests
    rd_mode = 2;
    ovf_seen = 0;
    n_big = 0;
    for (int i = 0; i < 80; i++) begin
      int len;
      logic tu;
      len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(17, 20))
                                        : int'($urandom_range(1, DEPTH));
      tu = ($urandom_range(0, 5) == 0);
      if (len > DEPTH) n_big++;
      send(len, 8'h00, tu, 1'b1, 1'b1);
    end
    drain("rnd");
    chk("rnd_ovf_n", 32'(ovf_seen), 32'(n_big));

`ifdef FRAME_STATS_EN
    chk("st_good", 32'(good_frames), 32'(m_good));
    chk("st_bad", 32'(bad_frames), 32'(m_bad));
    chk("st_ovf", 32'(ovf_frames), 32'(m_ovf));
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    @(negedge clk);
    chk("st_clr_good", 32'(good_frames), 0);
    chk("st_clr_bad", 32'(bad_frames), 0);
    chk("st_clr_ovf", 32'(ovf_frames), 0);
`endif

    // reset mid-read and mid-frame
    rd_mode = 0;
    tick();
    send(6, 8'h60, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("mid_ack1", 32'(pipe_ack), 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 8'hE0 + 8'(i);
      s_axis_tlast  = 1'b0;
      tick();
    end
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ack", 32'(pipe_ack), 0);
    chk("mid_rst_tready", 32'(s_axis_tready), 0);
    s_axis_tvalid = 1'b0;
    exp_q.delete();
    committed_w = 0;
    xfer_w = 0;
    m_good = 0;
    m_bad = 0;
    m_ovf = 0;
    tick();
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("post_rst_fr0", 32'(frames_ready), 0);
    chk("post_rst_ack0", 32'(pipe_ack), 0);
    rd_mode = 1;
    tick();
    send(7, 8'h55, 1'b0, 1'b0, 1'b0);
    drain("post");
`ifdef FRAME_STATS_EN
    chk("post_st_good", 32'(good_frames), 32'(m_good));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
